// File: rtl/parking_pkg.sv
// Shared types and helpers for the two-gate parking occupancy controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package parking_pkg;

  localparam int NGATES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    HOLD = 2'd2
  } gate_state_t;

  // Clamp a signed occupancy candidate into [0, cap].
  function automatic int sat_count(input int value, input int cap);
    if (value < 0) begin
      return 0;
    end
    if (value > cap) begin
      return cap;
    end
    return value;
  endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// Per-gate barrier FSM: IDLE -> OPEN on grant, OPEN -> HOLD on enter or timeout, HOLD -> IDLE on req drop.
// Latency: grant sampled at an edge opens the barrier right after that edge; enter closes it after the sampling edge.
// Backpressure: none; req is a level and a single request earns at most one grant (HOLD absorbs the rest).
module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter int OPEN_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  logic grant,
  input  logic enter,
  output logic open,
  output logic reserved,
  output logic idle_req
);

  localparam int TW = $clog2(OPEN_CYCLES);

  gate_state_t   state;
  gate_state_t   state_nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;

  // State and open-window timer registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Next-state, timer and decoded outputs; outputs depend on the registered state only
  // (idle_req additionally qualifies it with the live request level).
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    open      = 1'b0;
    reserved  = 1'b0;
    idle_req  = 1'b0;
    case (state)
      IDLE: begin
        idle_req = req;
        if (req && grant) begin
          state_nxt = OPEN;
          timer_nxt = TW'(OPEN_CYCLES - 1);
        end
      end
      OPEN: begin
        open     = 1'b1;
        reserved = 1'b1;
        if (enter) begin
          state_nxt = HOLD;
        end else if (timer == '0) begin
          state_nxt = HOLD;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      HOLD: begin
        if (!req) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Two-gate parking lot occupancy counter, slot arbitration and barrier control.
// Latency: one register stage; req/enter/exit sampled at an edge are reflected in outputs right after it.
// Backpressure: none; contested last slot goes round-robin, a full lot raises deny until a slot frees.
module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY    = 15,
  parameter int CNT_W       = 4,
  parameter int OPEN_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NGATES-1:0] req,
  input  logic [NGATES-1:0] enter,
  input  logic [NGATES-1:0] exit,
  output logic [NGATES-1:0] barrier_open,
  output logic [NGATES-1:0] deny,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              err_ovf,
  output logic              err_unf
);

  localparam logic signed [CNT_W+1:0] ZERO = '0;
  localparam logic signed [CNT_W+1:0] ONE  = (CNT_W+2)'(1);
  localparam logic signed [CNT_W+1:0] TWO  = (CNT_W+2)'(2);
  localparam logic signed [CNT_W+1:0] CAP  = (CNT_W+2)'(CAPACITY);

  logic [NGATES-1:0]       grant;
  logic [NGATES-1:0]       gate_rsv;
  logic [NGATES-1:0]       idle_req;
  logic [NGATES-1:0]       deny_nxt;
  logic [1:0]              rsv_cnt;
  logic [1:0]              enter_cnt;
  logic [1:0]              exit_cnt;
  logic signed [CNT_W+1:0] avail;
  logic signed [CNT_W+1:0] delta;
  logic signed [CNT_W+1:0] sum;
  logic [CNT_W-1:0]        count_nxt;
  logic                    ovf_hit;
  logic                    unf_hit;
  logic                    rr_ptr;
  logic                    rr_flip;

  for (genvar g = 0; g < NGATES; g++) begin : gen_gate
    parking_gate_fsm #(
      .OPEN_CYCLES(OPEN_CYCLES)
    ) u_gate (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req[g]),
      .grant    (grant[g]),
      .enter    (enter[g]),
      .open     (barrier_open[g]),
      .reserved (gate_rsv[g]),
      .idle_req (idle_req[g])
    );
  end

  // Slot arbitration on registered state: free slots exclude those held by open barriers.
  // avail is signed because tailgating can push count + reserved past CAPACITY.
  always_comb begin
    rsv_cnt  = {1'b0, gate_rsv[0]} + {1'b0, gate_rsv[1]};
    avail    = CAP - $signed({2'b00, count}) - $signed({{CNT_W{1'b0}}, rsv_cnt});
    grant    = '0;
    rr_flip  = 1'b0;
    if (&idle_req) begin
      if (avail >= TWO) begin
        grant = '1;
      end else if (avail == ONE) begin
        grant[rr_ptr] = 1'b1;
        rr_flip       = 1'b1;
      end
    end else if (|idle_req) begin
      if (avail >= ONE) begin
        grant = idle_req;
      end
    end
    deny_nxt = idle_req & ~grant;
  end

  // Net occupancy change from every pulse (barrier state ignored), saturated to [0, CAPACITY].
  always_comb begin
    enter_cnt = {1'b0, enter[0]} + {1'b0, enter[1]};
    exit_cnt  = {1'b0, exit[0]} + {1'b0, exit[1]};
    delta     = $signed({{CNT_W{1'b0}}, enter_cnt}) - $signed({{CNT_W{1'b0}}, exit_cnt});
    sum       = $signed({2'b00, count}) + delta;
    count_nxt = CNT_W'(sat_count(int'(sum), CAPACITY));
    ovf_hit   = (sum > CAP);
    unf_hit   = (sum < ZERO);
  end

  // Occupancy, flags, deny, sticky errors and round-robin pointer; full/empty track count_nxt
  // so they stay aligned with count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      deny    <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      rr_ptr  <= 1'b0;
    end else begin
      count   <= count_nxt;
      full    <= (count_nxt == CNT_W'(CAPACITY));
      empty   <= (count_nxt == '0);
      deny    <= deny_nxt;
      err_ovf <= err_ovf | ovf_hit;
      err_unf <= err_unf | unf_hit;
      rr_ptr  <= rr_ptr ^ rr_flip;
    end
  end

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed bench for parking_occupancy_ctrl with CAPACITY=3, OPEN_CYCLES=4.
// Each step drives one cycle of inputs and queues the outputs expected after the next edge;
// an independent monitor pops and compares on the falling edge.
module tb_parking_occupancy_ctrl;

  localparam int CAP = 3;
  localparam int CW  = 2;
  localparam int OC  = 4;

  typedef struct packed {
    logic [1:0]    bo;
    logic [1:0]    dn;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    req;
  logic [1:0]    enter;
  logic [1:0]    exit;
  logic [1:0]    barrier_open;
  logic [1:0]    deny;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          err_ovf;
  logic          err_unf;

  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  obs_t  exp_q[$];
  string name_q[$];
  int    cyc_q[$];
  obs_t  act;

  parking_occupancy_ctrl #(
    .CAPACITY   (CAP),
    .CNT_W      (CW),
    .OPEN_CYCLES(OC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .enter        (enter),
    .exit         (exit),
    .barrier_open (barrier_open),
    .deny         (deny),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .err_ovf      (err_ovf),
    .err_unf      (err_unf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation due in the current cycle.
  always @(negedge clk) begin
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      act = {barrier_open, deny, count, full, empty, err_ovf, err_unf};
      checks++;
      if (cyc_q[0] != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", name_q[0], cyc_q[0], cyc);
      end else if (act !== exp_q[0]) begin
        errors++;
        $display("FAIL %s: got bo=%b dn=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b, expected bo=%b dn=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b",
                 name_q[0], act.bo, act.dn, act.cnt, act.full, act.empty, act.ovf, act.unf,
                 exp_q[0].bo, exp_q[0].dn, exp_q[0].cnt, exp_q[0].full, exp_q[0].empty, exp_q[0].ovf, exp_q[0].unf);
      end
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
      void'(cyc_q.pop_front());
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic rst, input logic [1:0] r, input logic [1:0] en, input logic [1:0] ex,
                      input string nm, input logic [1:0] bo, input logic [1:0] dn, input int cnt,
                      input logic ovf, input logic unf);
    obs_t e;
    reset_n = rst;
    req     = r;
    enter   = en;
    exit    = ex;
    e.bo    = bo;
    e.dn    = dn;
    e.cnt   = CW'(cnt);
    e.full  = (cnt == CAP);
    e.empty = (cnt == 0);
    e.ovf   = ovf;
    e.unf   = unf;
    exp_q.push_back(e);
    name_q.push_back(nm);
    cyc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 2'b00;
    enter   = 2'b00;
    exit    = 2'b00;

    // Reset state, request ignored while in reset.
    step(0, 2'b00, 2'b00, 2'b00, "reset0", 2'b00, 2'b00, 0, 0, 0);
    step(0, 2'b01, 2'b00, 2'b00, "reset1", 2'b00, 2'b00, 0, 0, 0);

    // Gate 0 opens, enter during third open cycle closes it.
    step(1, 2'b01, 2'b00, 2'b00, "t1_open1", 2'b01, 2'b00, 0, 0, 0);
    step(1, 2'b01, 2'b00, 2'b00, "t1_open2", 2'b01, 2'b00, 0, 0, 0);
    step(1, 2'b01, 2'b00, 2'b00, "t1_open3", 2'b01, 2'b00, 0, 0, 0);
    step(1, 2'b01, 2'b01, 2'b00, "t1_enter", 2'b00, 2'b00, 1, 0, 0);
    step(1, 2'b00, 2'b00, 2'b00, "t1_idle",  2'b00, 2'b00, 1, 0, 0);
    step(1, 2'b00, 2'b00, 2'b01, "t1_exit",  2'b00, 2'b00, 0, 0, 0);

    // Gate 1 times out after exactly four open cycles and holds until req drops.
    step(1, 2'b10, 2'b00, 2'b00, "t2_open1",  2'b10, 2'b00, 0, 0, 0);
    step(1, 2'b10, 2'b00, 2'b00, "t2_open2",  2'b10, 2'b00, 0, 0, 0);
    step(1, 2'b10, 2'b00, 2'b00, "t2_open3",  2'b10, 2'b00, 0, 0, 0);
    step(1, 2'b10, 2'b00, 2'b00, "t2_open4",  2'b10, 2'b00, 0, 0, 0);
    step(1, 2'b10, 2'b00, 2'b00, "t2_hold1",  2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b10, 2'b00, 2'b00, "t2_hold2",  2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b00, 2'b00, "t2_drop",   2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b10, 2'b00, 2'b00, "t2_reopen", 2'b10, 2'b00, 0, 0, 0);
    step(1, 2'b10, 2'b10, 2'b00, "t2_enter",  2'b00, 2'b00, 1, 0, 0);
    step(1, 2'b00, 2'b00, 2'b00, "t2_idle",   2'b00, 2'b00, 1, 0, 0);

    // Tailgate to count 2, then contest the last slot twice: gate 0 wins, then gate 1.
    step(1, 2'b00, 2'b01, 2'b00, "t3_tailgate", 2'b00, 2'b00, 2, 0, 0);
    step(1, 2'b11, 2'b00, 2'b00, "t3_contest0", 2'b01, 2'b10, 2, 0, 0);
    step(1, 2'b11, 2'b00, 2'b00, "t3_wait",     2'b01, 2'b10, 2, 0, 0);
    step(1, 2'b11, 2'b01, 2'b00, "t3_enter0",   2'b00, 2'b10, 3, 0, 0);
    step(1, 2'b00, 2'b00, 2'b01, "t3_exit0",    2'b00, 2'b00, 2, 0, 0);
    step(1, 2'b11, 2'b00, 2'b00, "t3_contest1", 2'b10, 2'b01, 2, 0, 0);
    step(1, 2'b11, 2'b10, 2'b00, "t3_enter1",   2'b00, 2'b01, 3, 0, 0);

    // Full lot denies gate 0 until an exit frees a slot, then it is granted.
    step(1, 2'b01, 2'b00, 2'b00, "t4_deny",  2'b00, 2'b01, 3, 0, 0);
    step(1, 2'b01, 2'b00, 2'b10, "t4_exit1", 2'b00, 2'b01, 2, 0, 0);
    step(1, 2'b01, 2'b00, 2'b00, "t4_grant", 2'b01, 2'b00, 2, 0, 0);
    step(1, 2'b01, 2'b01, 2'b00, "t4_enter", 2'b00, 2'b00, 3, 0, 0);
    step(1, 2'b00, 2'b00, 2'b00, "t4_idle",  2'b00, 2'b00, 3, 0, 0);

    // Net-zero at full, overflow saturation, stickiness, underflow.
    step(1, 2'b00, 2'b01, 2'b10, "t5_net",    2'b00, 2'b00, 3, 0, 0);
    step(1, 2'b00, 2'b00, 2'b01, "t5_exit",   2'b00, 2'b00, 2, 0, 0);
    step(1, 2'b00, 2'b11, 2'b00, "t5_ovf",    2'b00, 2'b00, 3, 1, 0);
    step(1, 2'b00, 2'b00, 2'b01, "t5_sticky", 2'b00, 2'b00, 2, 1, 0);
    step(1, 2'b00, 2'b00, 2'b11, "t5_down",   2'b00, 2'b00, 0, 1, 0);
    step(1, 2'b00, 2'b00, 2'b01, "t5_unf",    2'b00, 2'b00, 0, 1, 1);

    // Reset while gate 0 is open clears everything.
    step(1, 2'b01, 2'b00, 2'b00, "t6_open",  2'b01, 2'b00, 0, 1, 1);
    step(0, 2'b01, 2'b00, 2'b00, "t6_reset", 2'b00, 2'b00, 0, 0, 0);
    step(1, 2'b00, 2'b00, 2'b00, "t6_after", 2'b00, 2'b00, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
